// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider sequencer: FSM state codes and watchdog default.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package div_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_OUT  = 2'b11;

  // Default watchdog limit: a bit-serial divider needs about n cycles, so 4n is generous.
  function automatic int tmo_default(input int width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Bundle of the upstream, downstream and divider-control signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: InValid/InReady upstream, OutValid/OutReady downstream.
interface div_sequencer_if #(
  parameter int n = 8
);
  logic         InValid;
  logic         InReady;
  logic [n-1:0] InA;
  logic [n-1:0] InB;
  logic         OutValid;
  logic         OutReady;
  logic [n-1:0] OutQ;
  logic [n-1:0] OutR;
  logic         OutDivZero;
  logic         OutTimeout;
  logic         DivS;
  logic         DivLA;
  logic         DivEB;
  logic [n-1:0] DivDataA;
  logic [n-1:0] DivDataB;
  logic         DivDone;
  logic [n-1:0] DivQ;
  logic [n-1:0] DivR;

  // Environment side: upstream producer, downstream consumer and the divider.
  modport master (
    output InValid, InA, InB, OutReady, DivDone, DivQ, DivR,
    input  InReady, OutValid, OutQ, OutR, OutDivZero, OutTimeout,
           DivS, DivLA, DivEB, DivDataA, DivDataB
  );

  // Sequencer side.
  modport slave (
    input  InValid, InA, InB, OutReady, DivDone, DivQ, DivR,
    output InReady, OutValid, OutQ, OutR, OutDivZero, OutTimeout,
           DivS, DivLA, DivEB, DivDataA, DivDataB
  );
endinterface

// File: rtl/div_sequencer_upcount_sat.sv
// Saturating up-counter used as the divider watchdog; tc flags count == LIMIT-1.
// Latency: tc follows the counter register, one cycle after each enabled increment.
// Backpressure: none; clear has priority over enable.
module upcount_sat #(
  parameter int W     = 6,
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  logic [W-1:0] count;

  // Count enabled cycles, holding at the terminal value instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != W'(LIMIT - 1))) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == W'(LIMIT - 1));
endmodule

// File: rtl/div_sequencer.sv
// Sequences one divide: accept operands, load and run an external divider, hold result.
// Latency: 2 + RUN cycles until DivDone (watchdog-bounded); zero divisor answers in 1 cycle.
// Backpressure: InReady only in IDLE with DivDone low; result held in OUT until OutReady.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int n    = 8,
  parameter int logn = 3,
  parameter int TMO  = tmo_default(n)
) (
  input logic             clk,
  input logic             rst,
  div_sequencer_if.slave  bus
);
  // Wide enough for the default limit (2^(logn+2)) and for any overridden TMO.
  localparam int CW = ((logn + 3) > $clog2(TMO + 1)) ? (logn + 3) : $clog2(TMO + 1);

  logic [1:0]   state;
  logic [n-1:0] op_a;
  logic [n-1:0] op_b;
  logic [n-1:0] res_q;
  logic [n-1:0] res_r;
  logic         div_zero;
  logic         timeout;
  logic         wd_tc;
  logic         accept;

  // Ready is gated by reset so the port reads 0 while reset is held.
  assign bus.InReady    = (state == ST_IDLE) & ~bus.DivDone & ~rst;
  assign accept         = bus.InValid & bus.InReady;
  assign bus.OutValid   = (state == ST_OUT);
  assign bus.DivS       = (state == ST_RUN);
  assign bus.DivLA      = (state == ST_LOAD);
  assign bus.DivEB      = (state == ST_LOAD);
  assign bus.DivDataA   = op_a;
  assign bus.DivDataB   = op_b;
  assign bus.OutQ       = res_q;
  assign bus.OutR       = res_r;
  assign bus.OutDivZero = div_zero;
  assign bus.OutTimeout = timeout;

  // Watchdog restarts from zero on every RUN entry and counts only RUN cycles.
  upcount_sat #(
    .W     (CW),
    .LIMIT (TMO)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_RUN),
    .enable (state == ST_RUN),
    .tc     (wd_tc)
  );

  // Control FSM plus operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      res_q    <= '0;
      res_r    <= '0;
      div_zero <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a <= bus.InA;
            op_b <= bus.InB;
            if (bus.InB == '0) begin
              // Divide by zero never touches the divider.
              res_q    <= '1;
              res_r    <= bus.InA;
              div_zero <= 1'b1;
              timeout  <= 1'b0;
              state    <= ST_OUT;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: state <= ST_RUN;
        ST_RUN: begin
          if (bus.DivDone) begin
            res_q    <= bus.DivQ;
            res_r    <= bus.DivR;
            div_zero <= 1'b0;
            timeout  <= 1'b0;
            state    <= ST_OUT;
          end else if (wd_tc) begin
            res_q    <= '0;
            res_r    <= '0;
            div_zero <= 1'b0;
            timeout  <= 1'b1;
            state    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.OutReady) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural divider attached.
// Latency: expected accept-to-valid latency is derived from the model and checked.
// Backpressure: OutReady is driven in directed holds and randomly.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int N     = 8;
  localparam int TMO_V = tmo_default(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_sequencer_if #(.n(N)) bus();

  div_sequencer #(.n(N), .logn(3), .TMO(TMO_V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       to;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Per-request divider behaviour chosen at accept time.
  int   pend_lat  = 1;
  logic pend_tie  = 1'b0;
  logic tie0      = 1'b0;
  int   force_lat = 0;

  // Behavioural divider: done after dv_lat DivS cycles, lingers dv_hold cycles after DivS drops.
  logic [7:0] dv_a, dv_b, dv_q, dv_r;
  logic       dv_done, dv_tie;
  int         dv_cnt, dv_lat, dv_hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_done <= 1'b0; dv_cnt <= 0; dv_lat <= 1; dv_hold <= 0; dv_tie <= 1'b0;
      dv_a <= 8'd0; dv_b <= 8'd1; dv_q <= 8'd0; dv_r <= 8'd0;
    end else begin
      if (bus.DivLA) begin
        dv_a <= bus.DivDataA; dv_cnt <= 0; dv_done <= 1'b0;
        dv_lat <= pend_lat; dv_tie <= pend_tie; dv_hold <= $urandom_range(0, 2);
      end
      if (bus.DivEB) dv_b <= bus.DivDataB;
      if (bus.DivS) begin
        if (!dv_done && !dv_tie) begin
          if (dv_cnt == dv_lat - 1) begin
            dv_done <= 1'b1; dv_q <= dv_a / dv_b; dv_r <= dv_a % dv_b;
          end
          dv_cnt <= dv_cnt + 1;
        end
      end else if (dv_done && !bus.DivLA) begin
        if (dv_hold > 0) dv_hold <= dv_hold - 1;
        else dv_done <= 1'b0;
      end
    end
  end

  assign bus.DivDone = dv_done;
  assign bus.DivQ    = dv_q;
  assign bus.DivR    = dv_r;

  // Monitor: invariants every cycle, latency/stability on results, scoreboard pop and push.
  int         cyc = 0;
  logic       prev_ov = 1'b0;
  logic [7:0] prev_q, prev_r;
  logic       prev_dz, prev_to;
  logic [7:0] last_a = 8'd0, last_b = 8'd0;
  logic       ctl_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_ov  = 1'b0;
      last_a   = 8'd0;
      last_b   = 8'd0;
      ctl_seen = 1'b0;
    end else begin
      exp_t e;
      cyc++;
      chk("ctl_overlap", bus.DivS & (bus.DivLA | bus.DivEB), 0);
      chk("ready_while_valid", bus.OutValid & bus.InReady, 0);
      chk("div_data_a", bus.DivDataA, last_a);
      chk("div_data_b", bus.DivDataB, last_b);
      if (bus.DivS | bus.DivLA | bus.DivEB) ctl_seen = 1'b1;
      if (bus.OutValid) begin
        if (!prev_ov) begin
          if (exp_q.size() == 0) chk("unexpected_result", exp_q.size(), 1);
          else chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
        end else begin
          chk("stable_q", bus.OutQ, prev_q);
          chk("stable_r", bus.OutR, prev_r);
          chk("stable_dz", bus.OutDivZero, prev_dz);
          chk("stable_to", bus.OutTimeout, prev_to);
        end
        if (bus.OutReady) begin
          if (exp_q.size() == 0) begin
            chk("pop_empty", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("out_q", bus.OutQ, e.q);
            chk("out_r", bus.OutR, e.r);
            chk("out_divzero", bus.OutDivZero, e.dz);
            chk("out_timeout", bus.OutTimeout, e.to);
            if (e.dz) chk("zero_div_ctl", ctl_seen, 0);
          end
        end
      end
      if (bus.InValid && bus.InReady) begin
        e.acc    = cyc;
        pend_tie = tie0;
        pend_lat = (force_lat > 0) ? force_lat : $urandom_range(1, 6);
        if (bus.InB == 8'd0) begin
          e.q = 8'hFF; e.r = bus.InA; e.dz = 1'b1; e.to = 1'b0; e.lat = 1;
        end else if (tie0) begin
          e.q = 8'd0; e.r = 8'd0; e.dz = 1'b0; e.to = 1'b1; e.lat = 2 + TMO_V;
        end else begin
          e.q = bus.InA / bus.InB; e.r = bus.InA % bus.InB;
          e.dz = 1'b0; e.to = 1'b0; e.lat = 3 + pend_lat;
        end
        exp_q.push_back(e);
        last_a   = bus.InA;
        last_b   = bus.InB;
        ctl_seen = 1'b0;
      end
      prev_ov = bus.OutValid;
      prev_q  = bus.OutQ;
      prev_r  = bus.OutR;
      prev_dz = bus.OutDivZero;
      prev_to = bus.OutTimeout;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int   k;
    logic acc;
    k = 0;
    acc = 1'b0;
    bus.InA = a;
    bus.InB = b;
    bus.InValid = 1'b1;
    while (!acc && k < 400) begin
      @(negedge clk);
      acc = bus.InValid && bus.InReady;
      @(posedge clk);
      #1;
      k++;
    end
    chk("accept", acc, 1);
  endtask

  task automatic wait_done(input bit rnd);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk);
      #1;
      if (rnd) bus.OutReady = ($urandom_range(0, 2) != 0);
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    bus.InValid  = 1'b0;
    bus.InA      = 8'd0;
    bus.InB      = 8'd0;
    bus.OutReady = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_outvalid", bus.OutValid, 0);
    chk("rst_inready", bus.InReady, 0);
    chk("rst_divs", bus.DivS, 0);
    chk("rst_divla", bus.DivLA, 0);
    chk("rst_diveb", bus.DivEB, 0);
    chk("rst_outq", bus.OutQ, 0);
    chk("rst_outr", bus.OutR, 0);
    chk("rst_divzero", bus.OutDivZero, 0);
    chk("rst_timeout", bus.OutTimeout, 0);
    chk("rst_data_a", bus.DivDataA, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain divide, immediate consume.
    bus.OutReady = 1'b1;
    send(8'd100, 8'd7);
    bus.InValid = 1'b0;
    wait_done(0);

    // Zero divisor.
    send(8'd55, 8'd0);
    bus.InValid = 1'b0;
    wait_done(0);

    // Result held under downstream backpressure.
    bus.OutReady = 1'b0;
    send(8'd200, 8'd3);
    bus.InValid = 1'b0;
    k = 0;
    while (!bus.OutValid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("hold_valid_seen", bus.OutValid, 1);
    repeat (10) begin
      @(negedge clk);
      chk("hold_inready", bus.InReady, 0);
      chk("hold_outvalid", bus.OutValid, 1);
    end
    @(posedge clk);
    #1;
    bus.OutReady = 1'b1;
    wait_done(0);

    // Divider never finishes: watchdog.
    tie0 = 1'b1;
    send(8'd9, 8'd2);
    bus.InValid = 1'b0;
    wait_done(0);
    tie0 = 1'b0;

    // Reset mid-RUN, then a clean request.
    force_lat = 20;
    send(8'd50, 8'd3);
    bus.InValid = 1'b0;
    k = 0;
    while (!bus.DivS && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("run_reached", bus.DivS, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_divs", bus.DivS, 0);
    chk("midrun_rst_valid", bus.OutValid, 0);
    chk("midrun_rst_inready", bus.InReady, 0);
    @(negedge clk);
    rst = 1'b0;
    force_lat = 0;
    @(posedge clk);
    #1;
    send(8'd255, 8'd16);
    bus.InValid = 1'b0;
    wait_done(0);

    // Back-to-back requests with InValid held high.
    send(8'd12, 8'd5);
    send(8'd7, 8'd7);
    bus.InValid = 1'b0;
    wait_done(0);

    // Randomized traffic with random downstream stalls.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      tie0 = ($urandom_range(0, 9) == 0);
      send(a, b);
      bus.InValid = 1'b0;
      wait_done(1);
    end
    tie0 = 1'b0;
    bus.OutReady = 1'b1;
    wait_done(0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter n, default 8: operand and result width in bits.
REQ-002 Parameter logn, default 3: log2(n).
REQ-003 Parameter TMO, default 4*n: watchdog limit, in cycles, while waiting for DivDone.
REQ-004 Clock  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 InValid  in  1  upstream has an operand pair.
REQ-007 InReady  out  1  sequencer accepts an operand pair this cycle.
REQ-008 InA, InB  in  n each  dividend and divisor, unsigned.
REQ-009 OutValid  out  1  result register holds a result.
REQ-010 OutReady  in  1  downstream consumes the result.
REQ-011 OutQ, OutR  out  n each  quotient and remainder.
REQ-012 OutDivZero, OutTimeout  out  1 each  status flags for the held result.
REQ-013 DivS, DivLA, DivEB  out  1 each  divider start, dividend load and divisor load controls.
REQ-014 DivDataA, DivDataB  out  n each  operands presented to the divider.
REQ-015 DivDone  in  1  divider completion.
REQ-016 DivQ, DivR  in  n each  divider results.

Function
REQ-017 The state machine SHALL have the states IDLE, LOAD, RUN and OUT.
REQ-018 IDLE: InReady = ~DivDone; a transfer occurs when InValid & InReady; operands latch into internal registers OpA and OpB.
REQ-019 IDLE transfer with InB != 0 SHALL go to LOAD.
REQ-020 IDLE transfer with InB == 0 SHALL go straight to OUT with OutQ = all ones, OutR = InA, OutDivZero = 1, and no DivS/DivLA/DivEB activity.
REQ-021 LOAD lasts exactly one cycle: DivLA = DivEB = 1, DivS = 0, DivDataA = OpA, DivDataB = OpB; then go to RUN.
REQ-022 RUN: DivS = 1, DivLA = DivEB = 0; the watchdog counter starts at 0 on RUN entry and increments each RUN cycle.
REQ-023 RUN with DivDone = 1 SHALL capture DivQ/DivR into OutQ/OutR with both flags = 0, then go to OUT.
REQ-024 RUN with the counter reaching TMO-1 and DivDone = 0 SHALL set OutQ = OutR = 0, OutTimeout = 1, then go to OUT.
REQ-025 OUT: OutValid = 1 and DivS = 0; outputs stay stable until OutReady = 1, then go to IDLE on the next edge.
REQ-026 OutValid = 0 in every state except OUT; InReady = 0 in every state except IDLE.
REQ-027 DivDataA/DivDataB SHALL show OpA/OpB in every state; DivLA/DivEB SHALL never be asserted in the same cycle as DivS.
REQ-028 Latency from accept to OutValid (nonzero divisor) SHALL be 2 + (number of RUN cycles until DivDone) cycles; the zero-divisor path SHALL take 1 cycle.
REQ-029 No new request SHALL be accepted while OutValid = 1, so no result is ever overwritten.
REQ-030 InValid while not in IDLE SHALL be ignored, with no state change.
REQ-031 DivDone = 1 in IDLE SHALL hold InReady low until DivDone = 0 (divider not yet back in its initial state).
REQ-032 OutReady during RUN SHALL be ignored.
REQ-033 The watchdog counter SHALL saturate and never wrap.

Reset
REQ-034 Reset SHALL asynchronously force state IDLE.
REQ-035 Reset values: OutValid = InReady = DivS = DivLA = DivEB = 0; OutQ = OutR = OpA = OpB = 0; both flags = 0; counter = 0.
REQ-036 Reset mid-RUN SHALL drop DivS immediately and discard the pending result; the first request after release completes normally.

Structure
REQ-037 State encoding (IDLE=2'b00, LOAD=2'b01, RUN=2'b10, OUT=2'b11) and the default TMO formula SHALL live in a shared package.
REQ-038 One sub-module SHALL implement the watchdog: upcount_sat (clear, enable, terminal-count flag).
REQ-039 All other logic SHALL stay in div_sequencer; a divider instance SHALL appear only in the testbench.

Verification
REQ-040 n=8, A=100, B=7, OutReady=1 with the real divider attached -> OutQ=14, OutR=2, flags=0, DivS high until DivDone.
REQ-041 A=55, B=0 -> OutValid one cycle after accept; OutQ=255, OutR=55, OutDivZero=1; DivS/DivLA/DivEB never high.
REQ-042 A=200, B=3 with OutReady held 0 for 10 cycles -> OutQ=66, OutR=2 stable throughout; InReady=0 until the cycle after OutReady=1.
REQ-043 DivDone tied 0, A=9, B=2 -> OutTimeout=1 exactly 32 RUN cycles after RUN entry; OutQ=OutR=0.
REQ-044 Reset pulsed for 1 cycle mid-RUN -> DivS=0 and state IDLE immediately; next request A=255, B=16 -> OutQ=15, OutR=15.
REQ-045 Back-to-back pairs (12,5) then (7,7) with InValid held high -> results (2,2) then (1,0), in order, none lost.
